pc_src_sequencer: RTL and testbench

//  Next-PC sequencer for the single-cycle core: decides PCSrc for the program counter each cycle from the decoded

---
 rtl/pc_src_sequencer_if.sv | 30 +++
 rtl/pc_src_sequencer.sv | 98 +++++++++
 tb/tb_pc_src_sequencer.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/pc_src_sequencer_if.sv
// Sequencer bus: decoded instruction class, IRQ/mask inputs and the PC-select/exception outputs.
interface pc_src_sequencer_if #(parameter int NUM_IRQ = 4);
  logic [31:0]        pc;
  logic               instr_valid;
  logic               is_branch;
  logic               is_jump;
  logic               is_jr;
  logic               jr_target31;
  logic               is_illegal;
  logic [NUM_IRQ-1:0] irq_req;
  logic               mask_we;
  logic [NUM_IRQ-1:0] mask_wdata;
  logic [2:0]         pc_src;
  logic               squash;
  logic [31:0]        epc;
  logic [3:0]         cause;
  logic [NUM_IRQ-1:0] irq_ack;
  logic               in_kernel;

  modport master (
    output pc, instr_valid, is_branch, is_jump, is_jr, jr_target31, is_illegal,
           irq_req, mask_we, mask_wdata,
    input  pc_src, squash, epc, cause, irq_ack, in_kernel
  );
  modport slave (
    input  pc, instr_valid, is_branch, is_jump, is_jr, jr_target31, is_illegal,
           irq_req, mask_we, mask_wdata,
    output pc_src, squash, epc, cause, irq_ack, in_kernel
  );
endinterface

// File: rtl/pc_src_sequencer.sv
// Next-PC source selection with edge-latched, masked, lowest-index-first IRQs and user/kernel tracking.
module pc_src_sequencer #(
  parameter int         NUM_IRQ   = 4,
  parameter logic [3:0] CAUSE_ILL = 4'hF
) (
  input  logic                 clk,
  input  logic                 reset,
  pc_src_sequencer_if.slave    bus
);
  typedef enum logic [1:0] {S_USER, S_ENTER, S_KERNEL} state_t;

  localparam logic [2:0] SRC_SEQ = 3'd0, SRC_BR = 3'd1, SRC_J = 3'd2,
                         SRC_JR = 3'd3, SRC_ILL = 3'd4, SRC_XADR = 3'd5;

  state_t             state, state_next;
  logic [NUM_IRQ-1:0] pending, mask, irq_prev, irq_ack, ack_next, eligible;
  logic [31:0]        epc;
  logic [3:0]         cause, winner;
  logic               take_irq, exc_take;
  logic [2:0]         pc_src;
  logic               squash;

  assign eligible = pending & mask;

  always_comb begin
    winner = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--)
      if (eligible[i]) winner = 4'(i);
  end

  assign take_irq = bus.instr_valid && (state == S_USER) && (eligible != '0);
  assign exc_take = take_irq || (bus.instr_valid && bus.is_illegal);
  // Isolating the lowest set bit gives the winner's one-hot ack directly.
  assign ack_next = take_irq ? (eligible & (~eligible + NUM_IRQ'(1))) : '0;

  always_comb begin
    pc_src     = SRC_SEQ;
    squash     = 1'b0;
    state_next = state;
    if (bus.instr_valid) begin
      if (take_irq) begin
        pc_src = SRC_XADR;
        squash = 1'b1;
      end else if (bus.is_illegal) begin
        pc_src = SRC_ILL;
        squash = 1'b1;
      end else if (bus.is_jr) pc_src = SRC_JR;
      else if (bus.is_jump)   pc_src = SRC_J;
      else if (bus.is_branch) pc_src = SRC_BR;
    end
    case (state)
      S_USER: begin
        if (take_irq) state_next = S_ENTER;
        else if (bus.instr_valid && bus.is_illegal) state_next = S_KERNEL;
      end
      S_ENTER: state_next = S_KERNEL;
      S_KERNEL: begin
        // eret: jr back to a user-space target, unless the same instruction is illegal
        if (bus.instr_valid && !bus.is_illegal && bus.is_jr && !bus.jr_target31)
          state_next = S_USER;
      end
      default: state_next = S_USER;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_USER;
    else       state <= state_next;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending  <= '0;
      mask     <= '0;
      irq_prev <= '0;
      irq_ack  <= '0;
      epc      <= '0;
      cause    <= '0;
    end else begin
      irq_prev <= bus.irq_req;
      // a new edge in the ack cycle must survive the clear
      pending  <= (pending & ~irq_ack) | (bus.irq_req & ~irq_prev);
      irq_ack  <= ack_next;
      if (bus.mask_we) mask <= bus.mask_wdata;
      if (exc_take) begin
        epc   <= bus.pc;
        cause <= take_irq ? winner : CAUSE_ILL;
      end
    end
  end

  assign bus.pc_src    = pc_src;
  assign bus.squash    = squash;
  assign bus.epc       = epc;
  assign bus.cause     = cause;
  assign bus.irq_ack   = irq_ack;
  assign bus.in_kernel = (state != S_USER);
endmodule

// File: tb/tb_pc_src_sequencer.sv
// Directed bench for pc_src_sequencer: expectations queued per step, popped and checked mid-cycle.
module tb_pc_src_sequencer;
  localparam int K_SRC = 0, K_SQ = 1, K_EPC = 2, K_CAUSE = 3, K_ACK = 4, K_KERN = 5;

  typedef struct {
    string       tag;
    int          kind;
    logic [31:0] val;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   vectors = 0;
  int   miscompares = 0;
  exp_t q[$];

  pc_src_sequencer_if #(.NUM_IRQ(4)) bus();

  pc_src_sequencer #(.NUM_IRQ(4), .CAUSE_ILL(4'hF)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] obs(input int kind);
    case (kind)
      K_SRC:   return 32'(bus.pc_src);
      K_SQ:    return 32'(bus.squash);
      K_EPC:   return bus.epc;
      K_CAUSE: return 32'(bus.cause);
      K_ACK:   return 32'(bus.irq_ack);
      default: return 32'(bus.in_kernel);
    endcase
  endfunction

  task automatic want(input string tag, input int kind, input logic [31:0] val);
    exp_t e;
    e.tag = tag; e.kind = kind; e.val = val;
    q.push_back(e);
  endtask

  task automatic check();
    exp_t        e;
    logic [31:0] got;
    #2;
    while (q.size() > 0) begin
      e   = q.pop_front();
      got = obs(e.kind);
      vectors++;
      assert (got === e.val) else begin
        miscompares++;
        $error("FAIL %s: observed %0h expected %0h", e.tag, got, e.val);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    bus.mask_we = 1'b0;
  endtask

  task automatic instr(input logic v, br, j, jr, t31, ill, input logic [31:0] p);
    bus.instr_valid = v;  bus.is_branch = br; bus.is_jump = j;
    bus.is_jr = jr;       bus.jr_target31 = t31; bus.is_illegal = ill;
    bus.pc = p;
  endtask

  task automatic want_src(input string tag, input logic [2:0] s, input logic sq);
    want({tag, "_src"}, K_SRC, 32'(s));
    want({tag, "_squash"}, K_SQ, 32'(sq));
  endtask

  initial begin
    reset = 1'b1;
    bus.irq_req = '0; bus.mask_we = 1'b0; bus.mask_wdata = '0;
    instr(0, 0, 0, 0, 0, 0, 32'h0);
    #2;
    want("rst_epc", K_EPC, 0); want("rst_cause", K_CAUSE, 0);
    want("rst_ack", K_ACK, 0); want("rst_kern", K_KERN, 0);
    want_src("rst", 3'd0, 1'b0);
    check();
    tick(); reset = 1'b0;

    // decode priority in user mode with nothing enabled
    tick(); instr(1, 1, 1, 1, 1, 0, 32'h0040_0000); want_src("jr_over_j_br", 3'd3, 0); check();
    tick(); instr(1, 1, 1, 0, 0, 0, 32'h0040_0004); want_src("j_over_br", 3'd2, 0); check();
    tick(); instr(1, 1, 0, 0, 0, 0, 32'h0040_0008); want_src("br", 3'd1, 0); check();
    tick(); instr(1, 0, 0, 0, 0, 0, 32'h0040_000c); want_src("seq", 3'd0, 0); check();
    tick(); instr(0, 0, 0, 1, 0, 1, 32'h0040_000c); want_src("bubble", 3'd0, 0); check();
    tick(); instr(1, 0, 0, 1, 0, 1, 32'h0040_000c); want_src("ill_over_jr", 3'd4, 1); check();
    tick();
    want("ill_epc", K_EPC, 32'h0040_000c); want("ill_cause", K_CAUSE, 4'hF);
    want("ill_kern", K_KERN, 1); want("ill_noack", K_ACK, 0);
    instr(1, 0, 0, 1, 0, 0, 32'h8000_0184); want_src("eret1", 3'd3, 0); check();

    // IRQ take: bits 1 and 2 rise together, bit 1 wins
    tick(); want("eret1_user", K_KERN, 0);
    bus.mask_we = 1'b1; bus.mask_wdata = 4'b0110;
    instr(0, 0, 0, 0, 0, 0, 32'h0040_0010); check();
    tick(); bus.irq_req = 4'b0110; instr(0, 0, 0, 0, 0, 0, 32'h0040_0010);
    want_src("edge_bubble", 3'd0, 0); check();
    tick(); instr(1, 0, 0, 0, 0, 0, 32'h0040_0010); want_src("take1", 3'd5, 1); check();
    tick();
    want("take1_epc", K_EPC, 32'h0040_0010); want("take1_cause", K_CAUSE, 1);
    want("take1_ack", K_ACK, 4'b0010); want("enter_kern", K_KERN, 1);
    instr(1, 0, 0, 0, 0, 0, 32'h8000_0180); want_src("enter_seq", 3'd0, 0); check();

    // kernel blocks pending bit 2; jr to kernel target stays, jr to user target returns
    tick(); want("ack_one_cycle", K_ACK, 0); want("kern_after_enter", K_KERN, 1);
    instr(1, 0, 0, 1, 1, 0, 32'h8000_0184); want_src("kern_jr_k", 3'd3, 0); check();
    tick(); want("kern_stay", K_KERN, 1);
    instr(1, 0, 0, 1, 0, 0, 32'h8000_0188); want_src("eret2", 3'd3, 0); check();
    tick(); want("eret2_user", K_KERN, 0); bus.irq_req = 4'b0000;
    instr(1, 0, 0, 0, 0, 0, 32'h0040_0100); want_src("take2", 3'd5, 1); check();

    // re-pulse bit 2 during its own ack cycle: the new edge must remain pending
    tick();
    want("take2_epc", K_EPC, 32'h0040_0100); want("take2_cause", K_CAUSE, 2);
    want("take2_ack", K_ACK, 4'b0100);
    bus.irq_req = 4'b0100; instr(0, 0, 0, 0, 0, 0, 32'h8000_0180); check();
    tick(); want("take2_ack_off", K_ACK, 0);
    instr(1, 0, 0, 1, 0, 0, 32'h8000_0184); want_src("eret3", 3'd3, 0); check();
    tick(); instr(1, 0, 0, 0, 0, 0, 32'h0040_0200); want_src("collide_take", 3'd5, 1); check();
    tick(); want("collide_cause", K_CAUSE, 2); want("collide_ack", K_ACK, 4'b0100);
    want("collide_epc", K_EPC, 32'h0040_0200); instr(0, 0, 0, 0, 0, 0, 32'h8000_0180); check();
    tick(); instr(1, 0, 0, 1, 0, 0, 32'h8000_0184); want_src("eret4", 3'd3, 0); check();
    tick(); want("eret4_user", K_KERN, 0); bus.irq_req = 4'b0101;
    instr(1, 0, 0, 0, 0, 0, 32'h0040_0300); want_src("cleared", 3'd0, 0); check();

    // masked pending bit 0, then enable it; mask takes effect the cycle after the write
    tick(); instr(1, 0, 0, 0, 0, 0, 32'h0040_0304); want_src("masked", 3'd0, 0); check();
    tick(); bus.mask_we = 1'b1; bus.mask_wdata = 4'b0001;
    instr(1, 0, 0, 0, 0, 0, 32'h0040_0308); want_src("mask_wr_cycle", 3'd0, 0); check();
    tick(); bus.irq_req = 4'b0111; instr(0, 0, 0, 0, 0, 0, 32'h0040_030c);
    want_src("mask_bubble", 3'd0, 0); check();
    tick(); want("bubble_no_state", K_KERN, 0);
    instr(1, 0, 0, 0, 0, 0, 32'h0040_0400); want_src("take0", 3'd5, 1); check();

    // async reset in the entry cycle
    tick();
    want("take0_ack", K_ACK, 4'b0001); want("take0_cause", K_CAUSE, 0);
    want("take0_epc", K_EPC, 32'h0040_0400); want("take0_kern", K_KERN, 1);
    instr(0, 0, 0, 0, 0, 0, 32'h8000_0180); check();
    bus.irq_req = 4'b0000; reset = 1'b1;
    want("arst_ack", K_ACK, 0); want("arst_kern", K_KERN, 0);
    want("arst_epc", K_EPC, 0); want("arst_cause", K_CAUSE, 0);
    check();
    #1 reset = 1'b0;
    tick(); bus.irq_req = 4'b1000; instr(0, 0, 0, 0, 0, 0, 32'h0040_0500); check();
    tick(); bus.mask_we = 1'b1; bus.mask_wdata = 4'b1111;
    instr(1, 0, 0, 0, 0, 0, 32'h0040_0500); want_src("mask_reset", 3'd0, 0); check();
    tick(); instr(1, 0, 0, 0, 0, 0, 32'h0040_0504); want_src("take3", 3'd5, 1); check();
    tick(); want("pending_reset_cause", K_CAUSE, 3); want("take3_ack", K_ACK, 4'b1000);
    instr(0, 0, 0, 0, 0, 0, 32'h8000_0180); check();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
